// File: rtl/conv_fp_share_arb.sv
// Two-requester scheduler time-sharing one in-order FP convolution core; owner tags ride an in-order FIFO.
// Define CONV_FP_SHARE_ARB_STRICT_PRIO_EN for fixed A-over-B priority (default: round-robin).
module conv_fp_share_arb #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 9,
  parameter int WINDOW_HEIGHT = 1,
  parameter int TAG_DEPTH     = 16,
  localparam int FP_WIDTH     = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int CNT_W        = $clog2(TAG_DEPTH) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] a_window_i,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] a_kernel_i,
  input  logic [15:0] a_col_i,
  input  logic [15:0] a_row_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] b_window_i,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] b_kernel_i,
  input  logic [15:0] b_col_i,
  input  logic [15:0] b_row_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] conv_window_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] conv_kernel_o,
  output logic [15:0] conv_col_o,
  output logic [15:0] conv_row_o,
  output logic        conv_valid_o,
  input  logic [FP_WIDTH-1:0] conv_data_i,
  input  logic [15:0] conv_col_i,
  input  logic [15:0] conv_row_i,
  input  logic        conv_valid_i,
  output logic [FP_WIDTH-1:0] a_data_o,
  output logic [15:0] a_col_o,
  output logic [15:0] a_row_o,
  output logic        a_valid_o,
  output logic [FP_WIDTH-1:0] b_data_o,
  output logic [15:0] b_col_o,
  output logic [15:0] b_row_o,
  output logic        b_valid_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic        err_o
);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic             r_run;
  logic [CNT_W-1:0] r_inflight;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_tag_mem [TAG_DEPTH];
  logic             r_err;

  logic w_credit;
  logic w_a_grant;
  logic w_b_grant;
  logic w_issue;
  logic w_empty;
  logic w_pop;
  logic w_owner;

  // r_run keeps both readies low until the first clock edge after reset release.
  assign w_credit = r_run & (r_inflight < CNT_W'(TAG_DEPTH));

`ifdef CONV_FP_SHARE_ARB_STRICT_PRIO_EN
  assign w_a_grant = w_credit & a_valid_i;
  assign w_b_grant = w_credit & b_valid_i & ~a_valid_i;
`else
  logic r_prio;  // 0 = A, 1 = B
  assign w_a_grant = w_credit & a_valid_i & (~r_prio | ~b_valid_i);
  assign w_b_grant = w_credit & b_valid_i & (r_prio | ~a_valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio <= 1'b0;
    end else if (w_a_grant) begin
      r_prio <= 1'b1;
    end else if (w_b_grant) begin
      r_prio <= 1'b0;
    end
  end
`endif

  assign w_issue    = w_a_grant | w_b_grant;
  assign w_empty    = (r_inflight == '0);
  assign w_pop      = conv_valid_i & ~w_empty;
  assign w_owner    = r_tag_mem[r_rd_ptr];
  assign a_ready_o  = w_a_grant;
  assign b_ready_o  = w_b_grant;
  assign inflight_o = r_inflight;
  assign err_o      = r_err;

  // Tag storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_tag_mem[r_wr_ptr] <= w_b_grant;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run         <= 1'b0;
      r_inflight    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_err         <= 1'b0;
      conv_window_o <= '0;
      conv_kernel_o <= '0;
      conv_col_o    <= '0;
      conv_row_o    <= '0;
      conv_valid_o  <= 1'b0;
      a_data_o      <= '0;
      a_col_o       <= '0;
      a_row_o       <= '0;
      a_valid_o     <= 1'b0;
      b_data_o      <= '0;
      b_col_o       <= '0;
      b_row_o       <= '0;
      b_valid_o     <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      conv_valid_o <= w_issue;
      if (w_issue) begin
        conv_window_o <= w_b_grant ? b_window_i : a_window_i;
        conv_kernel_o <= w_b_grant ? b_kernel_i : a_kernel_i;
        conv_col_o    <= w_b_grant ? b_col_i : a_col_i;
        conv_row_o    <= w_b_grant ? b_row_i : a_row_i;
        r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
      end
      a_valid_o <= w_pop & ~w_owner;
      b_valid_o <= w_pop & w_owner;
      if (w_pop & ~w_owner) begin
        a_data_o <= conv_data_i;
        a_col_o  <= conv_col_i;
        a_row_o  <= conv_row_i;
      end
      if (w_pop & w_owner) begin
        b_data_o <= conv_data_i;
        b_col_o  <= conv_col_i;
        b_row_o  <= conv_row_i;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (conv_valid_i & w_empty) begin
        r_err <= 1'b1;
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_pop);
    end
  end
endmodule

// File: tb/tb_conv_fp_share_arb.sv
// Scoreboard bench for conv_fp_share_arb with a variable-latency in-order core stub.
module tb_conv_fp_share_arb;
  typedef logic [0:0][8:0][15:0] win_t;
  typedef struct packed {logic [15:0] d; logic [15:0] c; logic [15:0] r;} res_t;
  typedef struct packed {logic v; logic [15:0] d; logic [15:0] c; logic [15:0] r;} slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  win_t a_window = '0, a_kernel = '0, b_window = '0, b_kernel = '0;
  logic [15:0] a_col = '0, a_row = '0, b_col = '0, b_row = '0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready;
  win_t conv_window, conv_kernel;
  logic [15:0] conv_col, conv_row;
  logic conv_valid_o;
  logic [15:0] conv_data_i = '0, conv_col_i = '0, conv_row_i = '0;
  logic conv_valid_i = 1'b0;
  logic [15:0] a_data_o, a_col_o, a_row_o, b_data_o, b_col_o, b_row_o;
  logic a_valid_o, b_valid_o;
  logic [4:0] inflight;
  logic err;

  always #5 clk = ~clk;

  conv_fp_share_arb #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(9),
                      .WINDOW_HEIGHT(1), .TAG_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_window_i(a_window), .a_kernel_i(a_kernel), .a_col_i(a_col), .a_row_i(a_row),
    .a_valid_i(a_valid), .a_ready_o(a_ready),
    .b_window_i(b_window), .b_kernel_i(b_kernel), .b_col_i(b_col), .b_row_i(b_row),
    .b_valid_i(b_valid), .b_ready_o(b_ready),
    .conv_window_o(conv_window), .conv_kernel_o(conv_kernel),
    .conv_col_o(conv_col), .conv_row_o(conv_row), .conv_valid_o(conv_valid_o),
    .conv_data_i(conv_data_i), .conv_col_i(conv_col_i), .conv_row_i(conv_row_i),
    .conv_valid_i(conv_valid_i),
    .a_data_o(a_data_o), .a_col_o(a_col_o), .a_row_o(a_row_o), .a_valid_o(a_valid_o),
    .b_data_o(b_data_o), .b_col_o(b_col_o), .b_row_o(b_row_o), .b_valid_o(b_valid_o),
    .inflight_o(inflight), .err_o(err)
  );

  int n_checks = 0;
  int n_err = 0;
  res_t qa[$];
  res_t qb[$];
  int grants[$];
  int a_left = 0, b_left = 0;
  int lat = 5;
  logic inj = 1'b0;
  int inf_m = 0;
  logic run_m = 1'b0;
  logic prio_m = 1'b0;
  int max_inf = 0, run_len = 0, max_run = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic win_t rnd_win();
    win_t w;
    for (int i = 0; i < 9; i++) w[0][i] = 16'($urandom);
    return w;
  endfunction

  // Requester A driver
  initial begin
    int k = 0;
    logic hs, took;
    forever begin
      @(negedge clk);
      hs = a_valid & a_ready;
      @(posedge clk);
      took = hs & ~rst;
      if (took) begin
        qa.push_back('{d: a_window[0][0] ^ a_kernel[0][0], c: a_col, r: a_row});
        grants.push_back(0);
        a_left--;
        k++;
      end
      #1;
      if (a_left > 0) begin
        if (took || !a_valid) begin
          a_col = 16'(k); a_row = 16'hA000 + 16'(k);
          a_window = rnd_win(); a_kernel = rnd_win();
        end
        a_valid = 1'b1;
      end else begin
        a_valid = 1'b0;
      end
    end
  end

  // Requester B driver
  initial begin
    int k = 0;
    logic hs, took;
    forever begin
      @(negedge clk);
      hs = b_valid & b_ready;
      @(posedge clk);
      took = hs & ~rst;
      if (took) begin
        qb.push_back('{d: b_window[0][0] ^ b_kernel[0][0], c: b_col, r: b_row});
        grants.push_back(1);
        b_left--;
        k++;
      end
      #1;
      if (b_left > 0) begin
        if (took || !b_valid) begin
          b_col = 16'(k); b_row = 16'hB000 + 16'(k);
          b_window = rnd_win(); b_kernel = rnd_win();
        end
        b_valid = 1'b1;
      end else begin
        b_valid = 1'b0;
      end
    end
  end

  // In-order core stub with latency lat; inj forces a result with nothing issued
  initial begin
    slot_t slots[64];
    slot_t s;
    int cyc = 0;
    for (int i = 0; i < 64; i++) slots[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < 64; i++) slots[i] = '0;
        conv_valid_i = 1'b0;
      end else begin
        if (conv_valid_o)
          slots[(cyc + lat) % 64] = '{v: 1'b1, d: conv_window[0][0] ^ conv_kernel[0][0],
                                       c: conv_col, r: conv_row};
        s = slots[cyc % 64];
        slots[cyc % 64] = '0;
        conv_valid_i = s.v | inj;
        conv_data_i  = inj ? 16'h5A5A : s.d;
        conv_col_i   = s.c;
        conv_row_i   = s.r;
        inj = 1'b0;
      end
      cyc++;
    end
  end

  // Monitor: arbitration model, issue checks, inflight model, result scoreboard
  initial begin
    logic ha, hb, cvi, exp_ra, exp_rb, credit, pop;
    win_t ew, ek;
    logic [15:0] ec, er;
    res_t r;
    forever begin
      @(negedge clk);
      credit = run_m && (inf_m < 16);
`ifdef CONV_FP_SHARE_ARB_STRICT_PRIO_EN
      exp_ra = credit & a_valid;
      exp_rb = credit & b_valid & ~a_valid;
`else
      exp_ra = credit & a_valid & (~prio_m | ~b_valid);
      exp_rb = credit & b_valid & (prio_m | ~a_valid);
`endif
      chk("a_ready", 160'(a_ready), 160'(exp_ra));
      chk("b_ready", 160'(b_ready), 160'(exp_rb));
      ha = a_valid & a_ready;
      hb = b_valid & b_ready;
      ew = hb ? b_window : a_window;
      ek = hb ? b_kernel : a_kernel;
      ec = hb ? b_col : a_col;
      er = hb ? b_row : a_row;
      cvi = conv_valid_i;
      @(posedge clk);
      #1;
      if (rst) begin
        run_m = 1'b0; inf_m = 0; prio_m = 1'b0; run_len = 0;
      end else begin
        chk("conv_valid", 160'(conv_valid_o), 160'(ha | hb));
        if (ha | hb) begin
          chk("conv_col", 160'(conv_col), 160'(ec));
          chk("conv_row", 160'(conv_row), 160'(er));
          chk("conv_window", 160'(conv_window), 160'(ew));
          chk("conv_kernel", 160'(conv_kernel), 160'(ek));
        end
        pop = cvi && (inf_m > 0);
        inf_m = inf_m + int'(ha) + int'(hb) - int'(pop);
        chk("inflight", 160'(inflight), 160'(inf_m));
        if (inf_m > max_inf) max_inf = inf_m;
        if (ha) prio_m = 1'b1;
        else if (hb) prio_m = 1'b0;
        run_m = 1'b1;
        run_len = conv_valid_o ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        chk("ret_valid", 160'(a_valid_o | b_valid_o), 160'(pop));
        chk("ret_excl", 160'(a_valid_o & b_valid_o), 160'(0));
        if (a_valid_o) begin
          if (qa.size() == 0) chk("a_unexpected", 160'(1), 160'(0));
          else begin
            r = qa.pop_front();
            chk("a_result", 160'({a_data_o, a_col_o, a_row_o}), 160'(r));
          end
        end
        if (b_valid_o) begin
          if (qb.size() == 0) chk("b_unexpected", 160'(1), 160'(0));
          else begin
            r = qb.pop_front();
            chk("b_result", 160'({b_data_o, b_col_o, b_row_o}), 160'(r));
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(a_left == 0 && b_left == 0 && !a_valid && !b_valid &&
                           qa.size() == 0 && qb.size() == 0 && inf_m == 0)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 160'(n >= budget), 160'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 160'({a_ready, b_ready, conv_valid_o, a_valid_o, b_valid_o, err, inflight,
                   conv_col, conv_row, a_data_o, a_col_o, b_data_o, b_row_o}), 160'(0));
    chk({tag, "_win"}, 160'(conv_window), 160'(0));
  endtask

  initial begin
    int i;
    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // A-only stream, latency 5
    lat = 5; max_run = 0;
    @(negedge clk) a_left = 20;
    wait_idle(300);
    chk("a_only_run", 160'(max_run), 160'(20));
    chk("a_only_grants", 160'(grants.size()), 160'(20));

    // Contention from reset release
    @(negedge clk) rst = 1'b1;
    grants.delete();
    a_left = 10; b_left = 10;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_idle(300);
    chk("cont_grants", 160'(grants.size()), 160'(20));
    for (i = 0; i < grants.size(); i++) begin
`ifdef CONV_FP_SHARE_ARB_STRICT_PRIO_EN
      chk($sformatf("grant%0d", i), 160'(grants[i]), 160'(i >= 10));
`else
      chk($sformatf("grant%0d", i), 160'(grants[i]), 160'(i % 2));
`endif
    end

    // Credit limit, latency 40
    lat = 40; max_inf = 0;
    @(negedge clk) begin a_left = 20; b_left = 20; end
    wait_idle(1000);
    chk("credit_max", 160'(max_inf), 160'(16));

    // Empty pop
    chk("err_before", 160'(err), 160'(0));
    @(negedge clk) inj = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("err_set", 160'(err), 160'(1));
    chk("err_inflight", 160'(inflight), 160'(0));
    repeat (5) @(posedge clk);
    #2 chk("err_sticky", 160'(err), 160'(1));

    // Reset mid-stream with 5 beats in flight
    lat = 20;
    @(negedge clk) begin a_left = 10; b_left = 10; end
    i = 0;
    while (i < 50 && inflight != 5) begin
      @(negedge clk);
      i++;
    end
    chk("mid_inflight5", 160'(inflight), 160'(5));
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    qa.delete(); qb.delete(); grants.delete();
    a_left = 3; b_left = 3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_idle(300);
    chk("post_rst_grants", 160'(grants.size()), 160'(6));
    if (grants.size() > 0) chk("post_rst_first", 160'(grants[0]), 160'(0));
    chk("post_rst_err", 160'(err), 160'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
